// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it as 16-bit words into instruction memory, holding the CPU in reset
// while a load is in progress or after a failed load.
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter bit          BOOT_HOLD = 1'b0,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;          // LEN_HI during the header, then the high data byte
  logic [7:0]  lo_q, lo_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;        // words still to be written
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tcnt_q, tcnt_d;      // idle cycles since the last accepted byte
  logic        boot_pend_q, boot_pend_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        accept;
  logic        counting;

  // Next-state logic; all outputs are derived from the next state so they are registered.
  always_comb begin
    accept      = in_valid && in_ready_q;
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    tcnt_d      = tcnt_q;
    boot_pend_d = boot_pend_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept) begin
          hi_d    = in_data;
          csum_d  = in_data;
          addr_d  = BASE_ADDR;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          cnt_d   = {hi_q, in_data};
          csum_d  = csum_q ^ in_data;
          state_d = ({hi_q, in_data} == 16'd0) ? S_CSUM : S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog: only waiting states count; the write cycle never does.
    counting = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) ||
               (state_q == S_DATA_LO) || (state_q == S_CSUM);
    if ((TIMEOUT == 0) || !counting || accept) begin
      tcnt_d = 32'd0;
    end else if (tcnt_q == 32'(TIMEOUT - 1)) begin
      tcnt_d  = 32'd0;
      state_d = S_ERR;
    end else begin
      tcnt_d = tcnt_q + 32'd1;
    end

    if (state_d == S_DONE) boot_pend_d = 1'b0;

    busy_d     = (state_d == S_LEN_LO) || (state_d == S_DATA_HI) ||
                 (state_d == S_DATA_LO) || (state_d == S_WRITE) || (state_d == S_CSUM);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    mem_we_d   = (state_d == S_WRITE);
    in_ready_d = (state_d != S_WRITE);
    cpu_rst_d  = busy_d || (state_d == S_ERR) || boot_pend_d;
  end

  // State and registered outputs; reset aborts any load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hi_q        <= 8'd0;
      lo_q        <= 8'd0;
      addr_q      <= 16'd0;
      cnt_q       <= 16'd0;
      csum_q      <= 8'd0;
      tcnt_q      <= 32'd0;
      boot_pend_q <= BOOT_HOLD;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_q   <= BOOT_HOLD;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      tcnt_q      <= tcnt_d;
      boot_pend_q <= boot_pend_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_q   <= cpu_rst_d;
    end
  end

  assign in_ready = in_ready_q;
  assign mem_addr = addr_q;
  assign mem_data = {hi_q, lo_q};
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_rst  = cpu_rst_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'h0000, the first memory word address written by every load.
REQ-002 The block SHALL have parameter BOOT_HOLD, default 0; when 1, cpu_rst is held asserted from reset until the first successful load.
REQ-003 The block SHALL have parameter TIMEOUT, default 0 (disabled), the maximum idle cycles allowed between bytes inside a frame.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_data, input, 8 bits, the byte-stream data.
REQ-007 The block SHALL have port in_valid, input, 1 bit, qualifying in_data.
REQ-008 The block SHALL have port in_ready, output, 1 bit; a byte is accepted in any cycle where in_valid and in_ready are both 1.
REQ-009 The block SHALL have port mem_addr, output, 16 bits, the instruction-memory write address.
REQ-010 The block SHALL have port mem_data, output, 16 bits, the instruction-memory write data.
REQ-011 The block SHALL have port mem_we, output, 1 bit, a single-cycle write strobe.
REQ-012 The block SHALL have port cpu_rst, output, 1 bit, the processor reset, active-high.
REQ-013 The block SHALL have ports busy, done and err, output, 1 bit each, giving load status.

Function
REQ-014 Frame format SHALL be: LEN_HI, LEN_LO, then N words sent high byte first, then CHK, where N = {LEN_HI, LEN_LO} and CHK = XOR of all preceding bytes in the frame.
REQ-015 The FSM SHALL have states IDLE, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, DONE and ERR.
REQ-016 In IDLE, DONE and ERR, accepting a byte SHALL: store it as LEN_HI, seed the checksum with it, set the address to BASE_ADDR, clear done and err, assert cpu_rst, and go to LEN_LO.
REQ-017 In LEN_LO, an accepted byte SHALL load the word counter; the next state SHALL be CSUM if N==0, otherwise DATA_HI.
REQ-018 In DATA_HI, an accepted byte SHALL be latched as the high byte; the next state SHALL be DATA_LO.
REQ-019 In DATA_LO, an accepted byte SHALL complete the word; the next state SHALL be WRITE.
REQ-020 WRITE SHALL last exactly one cycle, with mem_we=1, mem_addr = the current address, mem_data = {hi, lo} and in_ready=0.
REQ-021 At the end of WRITE, the address SHALL increment modulo 2^16 (FFFF wraps to 0000) and the counter SHALL decrement; the next state SHALL be CSUM if the counter reaches 0, otherwise DATA_HI.
REQ-022 In CSUM, an accepted byte equal to the running XOR SHALL go to DONE; an unequal byte SHALL go to ERR.
REQ-023 DONE SHALL drive done=1 and cpu_rst=0.
REQ-024 ERR SHALL drive err=1 and cpu_rst=1; the processor stays held until a later load succeeds.
REQ-025 in_ready SHALL be 1 in every state except WRITE.
REQ-026 busy SHALL be 1 in LEN_LO, DATA_HI, DATA_LO, WRITE and CSUM.
REQ-027 cpu_rst SHALL equal busy OR (state==ERR) OR (BOOT_HOLD AND no successful load since reset).
REQ-028 Every byte accepted in LEN_LO, DATA_HI and DATA_LO SHALL be XORed into the checksum.
REQ-029 When TIMEOUT>0 and busy=1, a counter SHALL count cycles without an accepted byte (WRITE cycles excluded); reaching TIMEOUT SHALL go to ERR.
REQ-030 The timeout counter SHALL clear on every accepted byte.
REQ-031 The maximum frame length SHALL be N=65535; N words SHALL produce exactly N mem_we pulses at consecutive addresses.

Reset
REQ-032 While rst=1, the state SHALL be IDLE and all of the following SHALL be 0: mem_addr, mem_data, mem_we, done, err, busy, counters and checksum.
REQ-033 While rst=1, cpu_rst SHALL equal BOOT_HOLD; in_ready SHALL be 0.
REQ-034 After rst deasserts, in_ready SHALL be 1 on the first clock edge.
REQ-035 Reset asserted mid-frame SHALL abort the load immediately, with no further mem_we; writes already done are not undone.

Verification
REQ-036 Frame bytes 00 02 12 34 AB CD 42 -> writes (0000,1234) then (0001,ABCD); done=1, cpu_rst=0, err=0.
REQ-037 Frame bytes 00 00 00 -> no mem_we; DONE reached on the third byte.
REQ-038 Frame bytes 00 01 11 22 FF (expected CHK 32) -> one write (0000,1122), then err=1, cpu_rst=1. A following valid frame 00 01 11 22 32 -> done=1, err=0.
REQ-039 BASE_ADDR=FFFF with frame 00 02 00 01 00 02 01 -> writes at FFFF then 0000; done=1.
REQ-040 TIMEOUT=16, stall after 00 01 -> ERR on the 16th idle cycle; with in_valid held continuously, in_ready is 0 for exactly one cycle per word.
REQ-041 Assert rst after the 4th byte of a 3-word frame -> state returns to IDLE, no mem_we, done=0, err=0.
